score_keeper: RTL and testbench

- Downstream consumer of the game controller's 5-bit `score` and of the signal controller's `play`/`gameover` phase flags.
- Tracks the current-game score with saturation, latches the final score at game over, and maintains a session high score.
- Emits registered BCD digits for the seven-segment hex drivers, plus a blink-blank strobe that flashes the high-score digits when a new record is set.

---
 rtl/score_pkg.sv | 15 +
 rtl/bin_to_bcd5.sv | 26 ++
 rtl/score_keeper.sv | 168 ++++++++++++++++
 tb/tb_score_keeper.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and default constants for the score keeper.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PLAYING = 2'b01,
      FINAL   = 2'b10
   } phase_e;

   typedef logic [3:0] bcd_t;

   localparam int MAX_SCORE_DEFAULT    = 18;
   localparam int BLINK_FRAMES_DEFAULT = 30;

endpackage

// File: rtl/bin_to_bcd5.sv
// Combinational 5-bit binary (0..31) to two-digit BCD converter.
module bin_to_bcd5
   import score_pkg::*;
(
   input  logic [4:0] bin,
   output bcd_t       tens,
   output bcd_t       ones
);

   always_comb begin
      if (bin >= 5'd30) begin
         tens = 4'd3;
         ones = 4'(bin - 5'd30);
      end else if (bin >= 5'd20) begin
         tens = 4'd2;
         ones = 4'(bin - 5'd20);
      end else if (bin >= 5'd10) begin
         tens = 4'd1;
         ones = 4'(bin - 5'd10);
      end else begin
         tens = 4'd0;
         ones = bin[3:0];
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Current/final/high score tracker with BCD outputs for the hex drivers.
// Define SCORE_BLINK_EN to build the frame-synchronised high-score blink logic.
module score_keeper
   import score_pkg::*;
#(
   parameter int MAX_SCORE    = MAX_SCORE_DEFAULT,
   parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       play,
   input  logic       gameover,
   input  logic [4:0] score,
   output bcd_t       cur_tens,
   output bcd_t       cur_ones,
   output bcd_t       high_tens,
   output bcd_t       high_ones,
   output logic       high_blank,
   output logic       new_high,
   output logic [1:0] phase
);

   phase_e     state_q, state_d;
   logic [4:0] cur_score_q, cur_score_d;
   logic [4:0] high_score_q, high_score_d;
   logic       new_high_q, new_high_d;
   logic [4:0] sat_score;
   logic       enter_playing;
   bcd_t       cur_tens_d, cur_ones_d, high_tens_d, high_ones_d;
   bcd_t       cur_tens_q, cur_ones_q, high_tens_q, high_ones_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (gameover)  state_d = FINAL;
            else if (play) state_d = PLAYING;
         end
         PLAYING: begin
            if (gameover)  state_d = FINAL;
            else if (!play) state_d = IDLE;
         end
         FINAL: begin
            if (!gameover) state_d = play ? PLAYING : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The final score is the saturated sample taken on the edge leaving PLAYING.
   always_comb begin
      sat_score     = (score > 5'(MAX_SCORE)) ? 5'(MAX_SCORE) : score;
      enter_playing = (state_d == PLAYING) && (state_q != PLAYING);
      cur_score_d   = cur_score_q;
      high_score_d  = high_score_q;
      new_high_d    = new_high_q;
      if (enter_playing) begin
         cur_score_d = 5'd0;
         new_high_d  = 1'b0;
      end else if (state_q == PLAYING) begin
         cur_score_d = sat_score;
         if (state_d == FINAL) begin
            if (sat_score > high_score_q) begin
               high_score_d = sat_score;
               new_high_d   = 1'b1;
            end else begin
               new_high_d = 1'b0;
            end
         end
      end
   end

   bin_to_bcd5 u_cur_bcd (
      .bin  (cur_score_q),
      .tens (cur_tens_d),
      .ones (cur_ones_d)
   );

   bin_to_bcd5 u_high_bcd (
      .bin  (high_score_q),
      .tens (high_tens_d),
      .ones (high_ones_d)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= IDLE;
         cur_score_q  <= 5'd0;
         high_score_q <= 5'd0;
         new_high_q   <= 1'b0;
         cur_tens_q   <= 4'd0;
         cur_ones_q   <= 4'd0;
         high_tens_q  <= 4'd0;
         high_ones_q  <= 4'd0;
      end else begin
         state_q      <= state_d;
         cur_score_q  <= cur_score_d;
         high_score_q <= high_score_d;
         new_high_q   <= new_high_d;
         cur_tens_q   <= cur_tens_d;
         cur_ones_q   <= cur_ones_d;
         high_tens_q  <= high_tens_d;
         high_ones_q  <= high_ones_d;
      end
   end

   assign cur_tens  = cur_tens_q;
   assign cur_ones  = cur_ones_q;
   assign high_tens = high_tens_q;
   assign high_ones = high_ones_q;
   assign new_high  = new_high_q;
   assign phase     = state_q;

`ifdef SCORE_BLINK_EN
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [2:0]       frame_sync_q, frame_sync_d;
   logic             frame_tick;
   logic             enter_final;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;
   logic             high_blank_q, high_blank_d;

   // Bits [1:0] synchronise frame_clk; bit [2] remembers the previous level.
   always_comb begin
      frame_sync_d = {frame_sync_q[1:0], frame_clk};
      frame_tick   = frame_sync_q[1] & ~frame_sync_q[2];
      enter_final  = (state_d == FINAL) && (state_q != FINAL);
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (enter_final) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if ((state_q == FINAL) && new_high_q && frame_tick) begin
         if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
      high_blank_d = (state_d == FINAL) & new_high_d & blink_phase_d;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         frame_sync_q  <= 3'b000;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         high_blank_q  <= 1'b0;
      end else begin
         frame_sync_q  <= frame_sync_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         high_blank_q  <= high_blank_d;
      end
   end

   assign high_blank = high_blank_q;
`else
   logic unused_blink_cfg;

   assign unused_blink_cfg = frame_clk ^ (BLINK_FRAMES > 1);
   assign high_blank       = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed tables, hand sequences and
// randomized play checked against a behavioural model of the score rules.
module tb_score_keeper;
   import score_pkg::*;

   localparam int MAXS   = 18;
   localparam int BLINKF = 4;

   logic       Clk;
   logic       Reset;
   logic       frame_clk;
   logic       play;
   logic       gameover;
   logic [4:0] score;
   bcd_t       cur_tens, cur_ones, high_tens, high_ones;
   logic       high_blank, new_high;
   logic [1:0] phase;

   int checks;
   int failures;

   // Behavioural model: mode 0/1/2, scores as plain integers
   int m_mode, m_cur, m_high, m_nh, m_dcur, m_dhigh;

   typedef struct {
      logic [4:0] score;
      int         exp_tens;
      int         exp_ones;
   } sat_vec_t;

   sat_vec_t satTable[22];

   score_keeper #(.MAX_SCORE(MAXS), .BLINK_FRAMES(BLINKF)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .play       (play),
      .gameover   (gameover),
      .score      (score),
      .cur_tens   (cur_tens),
      .cur_ones   (cur_ones),
      .high_tens  (high_tens),
      .high_ones  (high_ones),
      .high_blank (high_blank),
      .new_high   (new_high),
      .phase      (phase)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic applyStimulus(input logic p, input logic g, input int s);
      play     = p;
      gameover = g;
      score    = 5'(s);
   endtask

   task automatic pulseFrame();
      frame_clk = 1'b1;
      waitCycles(3);
      frame_clk = 1'b0;
      waitCycles(3);
   endtask

   task automatic applyReset();
      Reset = 1'b0;
      waitCycles(1);
      Reset = 1'b1;
      m_mode = 0; m_cur = 0; m_high = 0; m_nh = 0; m_dcur = 0; m_dhigh = 0;
   endtask

   // One clock edge of the scoring rules: gameover wins, then play, else idle.
   task automatic modelStep(input int p, input int g, input int s);
      int sat, nxt;
      sat = (s > MAXS) ? MAXS : s;
      nxt = g ? 2 : (p ? 1 : 0);
      m_dcur  = m_cur;
      m_dhigh = m_high;
      if (nxt == 1 && m_mode != 1) begin
         m_cur = 0;
         m_nh  = 0;
      end else if (m_mode == 1) begin
         m_cur = sat;
         if (nxt == 2) begin
            if (sat > m_high) begin
               m_high = sat;
               m_nh   = 1;
            end else begin
               m_nh = 0;
            end
         end
      end
      m_mode = nxt;
   endtask

   task automatic checkModel(input int cyc);
      string tag;
      tag = $sformatf("rnd%0d", cyc);
      checkOutput({tag, " phase"}, int'(phase), m_mode);
      checkOutput({tag, " cur_tens"}, int'(cur_tens), m_dcur / 10);
      checkOutput({tag, " cur_ones"}, int'(cur_ones), m_dcur % 10);
      checkOutput({tag, " high_tens"}, int'(high_tens), m_dhigh / 10);
      checkOutput({tag, " high_ones"}, int'(high_ones), m_dhigh % 10);
      checkOutput({tag, " new_high"}, int'(new_high), m_nh);
      checkOutput({tag, " high_blank"}, int'(high_blank), 0);
   endtask

   function automatic int expBlank(input int ticks);
`ifdef SCORE_BLINK_EN
      return (ticks / BLINKF) % 2;
`else
      return 0 * ticks;
`endif
   endfunction

   initial begin
      int sat;
      checks   = 0;
      failures = 0;

      for (int i = 0; i < 22; i++) begin
         satTable[i].score = (i < 19) ? 5'(i) : ((i == 19) ? 5'd19 : ((i == 20) ? 5'd25 : 5'd31));
         sat = (int'(satTable[i].score) > MAXS) ? MAXS : int'(satTable[i].score);
         satTable[i].exp_tens = sat / 10;
         satTable[i].exp_ones = sat % 10;
      end

      // Reset held with play asserted
      Reset     = 1'b0;
      frame_clk = 1'b0;
      applyStimulus(1'b1, 1'b0, 9);
      waitCycles(3);
      checkOutput("rst phase", int'(phase), 0);
      checkOutput("rst cur_tens", int'(cur_tens), 0);
      checkOutput("rst cur_ones", int'(cur_ones), 0);
      checkOutput("rst high_tens", int'(high_tens), 0);
      checkOutput("rst high_ones", int'(high_ones), 0);
      checkOutput("rst new_high", int'(new_high), 0);
      checkOutput("rst high_blank", int'(high_blank), 0);
      Reset = 1'b1;
      waitCycles(1);
      checkOutput("release phase", int'(phase), 1);

      // Saturation table
      for (int i = 0; i < 22; i++) begin
         applyStimulus(1'b1, 1'b0, int'(satTable[i].score));
         waitCycles(2);
         checkOutput($sformatf("sat%0d tens", satTable[i].score), int'(cur_tens), satTable[i].exp_tens);
         checkOutput($sformatf("sat%0d ones", satTable[i].score), int'(cur_ones), satTable[i].exp_ones);
      end
      checkOutput("sat phase", int'(phase), 1);

      // First game over with a new record, then blink
      applyStimulus(1'b1, 1'b0, 12);
      waitCycles(2);
      applyStimulus(1'b0, 1'b1, 12);
      waitCycles(1);
      checkOutput("go1 phase", int'(phase), 2);
      checkOutput("go1 new_high", int'(new_high), 1);
      waitCycles(1);
      checkOutput("go1 high_tens", int'(high_tens), 1);
      checkOutput("go1 high_ones", int'(high_ones), 2);
      checkOutput("go1 cur_ones", int'(cur_ones), 2);
      checkOutput("go1 high_blank", int'(high_blank), 0);
      for (int n = 1; n <= 10; n++) begin
         pulseFrame();
         checkOutput($sformatf("blink tick%0d", n), int'(high_blank), expBlank(n));
      end

      // Second game with a lower score
      applyStimulus(1'b1, 1'b0, 0);
      waitCycles(1);
      checkOutput("g2 phase", int'(phase), 1);
      checkOutput("g2 new_high", int'(new_high), 0);
      checkOutput("g2 high_blank", int'(high_blank), 0);
      waitCycles(1);
      checkOutput("g2 cur_tens", int'(cur_tens), 0);
      checkOutput("g2 cur_ones", int'(cur_ones), 0);
      applyStimulus(1'b1, 1'b0, 7);
      waitCycles(2);
      checkOutput("g2 cur7", int'(cur_ones), 7);
      applyStimulus(1'b0, 1'b1, 7);
      waitCycles(2);
      checkOutput("go2 phase", int'(phase), 2);
      checkOutput("go2 new_high", int'(new_high), 0);
      checkOutput("go2 high_tens", int'(high_tens), 1);
      checkOutput("go2 high_ones", int'(high_ones), 2);
      for (int n = 1; n <= 4; n++) pulseFrame();
      checkOutput("go2 high_blank", int'(high_blank), 0);

      // Simultaneous flags from IDLE
      applyStimulus(1'b0, 1'b0, 7);
      waitCycles(1);
      checkOutput("sim idle", int'(phase), 0);
      applyStimulus(1'b1, 1'b1, 30);
      waitCycles(2);
      checkOutput("sim phase", int'(phase), 2);
      checkOutput("sim new_high", int'(new_high), 0);
      checkOutput("sim high_ones", int'(high_ones), 2);
      checkOutput("sim high_tens", int'(high_tens), 1);

      // Randomized play against the model
      applyStimulus(1'b0, 1'b0, 0);
      waitCycles(1);
      applyReset();
      for (int c = 0; c < 400; c++) begin
         logic p, g;
         int   s;
         checkModel(c);
         p = ($urandom_range(0, 3) != 0);
         g = ($urandom_range(0, 7) == 0);
         s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 20));
         applyStimulus(p, g, s);
         @(posedge Clk);
         modelStep(int'(p), int'(g), s);
         @(negedge Clk);
      end

      // Reset while the high score is blinking
      applyStimulus(1'b0, 1'b0, 0);
      applyReset();
      applyStimulus(1'b1, 1'b0, 5);
      waitCycles(3);
      applyStimulus(1'b0, 1'b1, 5);
      waitCycles(2);
      checkOutput("mid new_high", int'(new_high), 1);
      checkOutput("mid high_ones", int'(high_ones), 5);
      for (int n = 1; n <= 5; n++) pulseFrame();
      checkOutput("mid high_blank", int'(high_blank), expBlank(5));
      #3 Reset = 1'b0;
      #2;
      checkOutput("async high_blank", int'(high_blank), 0);
      checkOutput("async high_ones", int'(high_ones), 0);
      checkOutput("async high_tens", int'(high_tens), 0);
      checkOutput("async cur_ones", int'(cur_ones), 0);
      checkOutput("async phase", int'(phase), 0);
      checkOutput("async new_high", int'(new_high), 0);
      waitCycles(1);
      Reset = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
